lane_cluster: RTL

//  - Parametrised multi-lane SIMT execution cluster; successor to the single processing lane.
//  - Issues one decoded ALU instruction to NUM_LANES lanes under a per-instruction lane mask.
//  - Each lane owns a private NUM_REGS x DATA_W register file.
//  - Sits between the warp scheduler (issue side) and the host/debug register access port.

---
 rtl/lane_cluster.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lane_cluster.sv
// Multi-lane SIMT execution cluster: one ALU instruction, NUM_LANES private register files, host access port.
// Optional feature: define SAT_ARITH_EN for saturating ADD/SUB/MUL.
package warp_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_MAX = 4'd3,
    OP_MIN = 4'd4
  } alu_opcode_e;
endpackage

module lane_cluster
  import warp_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [31:0]          instruction,
  input  logic [NUM_LANES-1:0] lane_mask,
  output logic                 done,
  output logic                 illegal_op,
  input  logic                 host_wr_en,
  input  logic [LW-1:0]        host_lane,
  input  logic [RW-1:0]        host_reg,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic [DATA_W-1:0]    host_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_READ, S_EXEC, S_WB} state_e;

  state_e                r_state, w_next;
  logic [31:0]           r_instr;
  logic [NUM_LANES-1:0]  r_mask;
  logic [3:0]            r_op;
  logic [RW-1:0]         r_dst, r_src1, r_src2;
  logic                  r_illegal;
  logic                  r_done, r_illegal_out;
  logic [DATA_W-1:0]     r_rf  [NUM_LANES][NUM_REGS];
  logic [DATA_W-1:0]     r_a   [NUM_LANES];
  logic [DATA_W-1:0]     r_b   [NUM_LANES];
  logic [DATA_W-1:0]     r_res [NUM_LANES];
  logic [DATA_W-1:0]     w_res [NUM_LANES];
  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_host_ok;
  logic                  w_unused;

`ifdef SAT_ARITH_EN
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W:0] s);
    if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? SMIN : SMAX;
    else return s[DATA_W-1:0];
  endfunction

  // Product fits only if its top DATA_W+1 bits are a pure sign extension.
  function automatic logic [DATA_W-1:0] sat_prod(input logic [2*DATA_W-1:0] p);
    if (p[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){p[2*DATA_W-1]}}) return p[2*DATA_W-1] ? SMIN : SMAX;
    else return p[DATA_W-1:0];
  endfunction
`endif

  function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
`ifdef SAT_ARITH_EN
      OP_ADD:  res = sat_sum({a[DATA_W-1], a} + {b[DATA_W-1], b});
      OP_SUB:  res = sat_sum({a[DATA_W-1], a} - {b[DATA_W-1], b});
      OP_MUL:  res = sat_prod({{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b});
`else
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
`endif
      OP_MAX:  res = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN:  res = ($signed(a) < $signed(b)) ? a : b;
      default: res = '0;
    endcase
    return res;
  endfunction

  assign issue_ready = (r_state == S_IDLE) && !host_wr_en;
  assign w_accept    = issue_valid && issue_ready;
  assign w_host_ok   = (int'(host_lane) < NUM_LANES) && (int'(host_reg) < NUM_REGS);
  assign done        = r_done;
  assign illegal_op  = r_illegal_out;
  assign w_unused    = ^{r_instr[27:23], r_instr[7:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_DECODE; else w_next = S_IDLE;
      S_DECODE: w_next = S_READ;
      S_READ:   w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_illegal = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB, OP_MUL, OP_MAX, OP_MIN: w_illegal = 1'b0;
      default:                                w_illegal = 1'b1;
    endcase
    for (int l = 0; l < NUM_LANES; l++) w_res[l] = alu(r_op, r_a[l], r_b[l]);
  end

  always_comb begin
    host_rdata = '0;
    if (w_host_ok && (host_reg != '0)) host_rdata = r_rf[host_lane][host_reg];
    else host_rdata = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_instr       <= '0;
      r_mask        <= '0;
      r_op          <= '0;
      r_dst         <= '0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_illegal     <= 1'b0;
      r_done        <= 1'b0;
      r_illegal_out <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_a[l]   <= '0;
        r_b[l]   <= '0;
        r_res[l] <= '0;
        for (int r = 0; r < NUM_REGS; r++) r_rf[l][r] <= '0;
      end
    end else begin
      r_state       <= w_next;
      r_done        <= (r_state == S_EXEC);
      r_illegal_out <= (r_state == S_EXEC) && w_illegal;
      if (w_accept) begin
        r_instr <= instruction;
        r_mask  <= lane_mask;
      end
      if (r_state == S_DECODE) begin
        r_op   <= r_instr[31:28];
        r_dst  <= r_instr[18 +: RW];
        r_src1 <= r_instr[13 +: RW];
        r_src2 <= r_instr[8 +: RW];
      end
      // R0 is never written, but the explicit zero keeps the read path independent of that.
      if (r_state == S_READ) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          r_a[l] <= (r_src1 == '0) ? '0 : r_rf[l][r_src1];
          r_b[l] <= (r_src2 == '0) ? '0 : r_rf[l][r_src2];
        end
      end
      if (r_state == S_EXEC) begin
        r_illegal <= w_illegal;
        for (int l = 0; l < NUM_LANES; l++) r_res[l] <= w_res[l];
      end
      if (r_state == S_WB) begin
        for (int l = 0; l < NUM_LANES; l++)
          if (r_mask[l] && (r_dst != '0) && !r_illegal) r_rf[l][r_dst] <= r_res[l];
      end
      if ((r_state == S_IDLE) && host_wr_en && w_host_ok && (host_reg != '0))
        r_rf[host_lane][host_reg] <= host_wdata;
    end
  end

endmodule
